// File: rtl/sme_pkg.sv
// Shared constants, widths and FSM state type for the string matching engine.
package sme_pkg;

  localparam int unsigned STR_MAX = 32;
  localparam int unsigned PAT_MAX = 8;
  localparam int unsigned IDX_W   = $clog2(STR_MAX);  // string index width
  localparam int unsigned SLEN_W  = IDX_W + 1;        // string length 0..STR_MAX
  localparam int unsigned POFF_W  = $clog2(PAT_MAX);  // pattern index width
  localparam int unsigned PLEN_W  = POFF_W + 1;       // pattern length 0..PAT_MAX
  localparam int unsigned POS_W   = 8;                // signed window position, covers -1..len+PAT_MAX

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_STR,
    LOAD_PAT,
    SEARCH,
    OUT
  } state_t;

endpackage

// File: rtl/sme_window_cmp.sv
// Combinational compare of one pattern segment against the string window
// starting at signed position pos. The string is framed by virtual spaces
// at index -1 and index str_len.
//   str/str_len     stored string and its length
//   pat             stored pattern
//   seg_off/seg_len segment of the pattern to compare (seg_len 0 = always hit)
//   pos             string position aligned with pattern char seg_off
//   hit_c           every segment char matches
module sme_window_cmp
  import sme_pkg::*;
(
  input  logic [7:0]              str [STR_MAX],
  input  logic [SLEN_W-1:0]       str_len,
  input  logic [7:0]              pat [PAT_MAX],
  input  logic [POFF_W-1:0]       seg_off,
  input  logic [PLEN_W-1:0]       seg_len,
  input  logic signed [POS_W-1:0] pos,
  output logic                    hit_c
);

  logic [PAT_MAX-1:0] care;
  logic [PAT_MAX-1:0] ok;

  for (genvar j = 0; j < PAT_MAX; j++) begin : g_ch
    logic signed [POS_W-1:0] idx;
    logic [POFF_W-1:0]       pidx;
    logic [7:0]              pc;
    logic [7:0]              sc;
    logic                    is_real;
    logic                    at_start;
    logic                    at_end;

    assign idx      = pos + $signed(POS_W'(j));
    assign pidx     = seg_off + POFF_W'(j);
    assign pc       = pat[pidx];
    assign sc       = str[idx[IDX_W-1:0]];
    assign is_real  = !idx[POS_W-1] && (idx < $signed(POS_W'(str_len)));
    assign at_start = (idx == '1);
    assign at_end   = (idx == $signed(POS_W'(str_len)));
    assign care[j]  = (PLEN_W'(j) < seg_len);

    // Per-character rule: wildcards first, otherwise exact compare on a real char
    always_comb begin
      ok[j] = 1'b0;
      if (pc == CH_DOT)         ok[j] = is_real;
      else if (pc == CH_CARET)  ok[j] = at_start || (is_real && sc == CH_SPACE);
      else if (pc == CH_DOLLAR) ok[j] = at_end || (is_real && sc == CH_SPACE);
      else                      ok[j] = is_real && (sc == pc);
    end
  end

  assign hit_c = &(~care | ok);

endmodule

// File: rtl/sme_string_match.sv
// String matching engine: serially loads a string (<=32 chars) and a pattern
// (<=8 chars, wildcards ^ $ . *), then reports the leftmost match.
//   clk, reset        clock, asynchronous active-low reset
//   chardata          byte qualified by isstring / ispattern
//   valid             one-cycle result pulse
//   match             pattern found (held until next result)
//   match_index       index of first matched char (0 when no match)
module sme_string_match
  import sme_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       chardata,
  input  logic             isstring,
  input  logic             ispattern,
  output logic             valid,
  output logic             match,
  output logic [IDX_W-1:0] match_index
);

  state_t state, state_next;

  logic [7:0]        str_buf [STR_MAX];
  logic [SLEN_W-1:0] str_len;
  logic [7:0]        pat_buf [PAT_MAX];
  logic [PLEN_W-1:0] pat_len;

  logic signed [POS_W-1:0] pos;
  logic signed [POS_W-1:0] best_pos;
  logic                    suf_seen;
  logic                    found;

  logic              has_star, has_caret;
  logic [PLEN_W-1:0] star_pos, pre_len, suf_off, suf_len;
  logic signed [POS_W-1:0] pos_min, suf_pos, win_pos, idx_full;
  logic pre_hit, suf_hit, suf_ok, cand_hit, search_done;

  // Pattern decode: split at the first '*' into prefix and suffix segments
  always_comb begin
    has_star = 1'b0;
    star_pos = '0;
    for (int j = 0; j < PAT_MAX; j++) begin
      if (!has_star && PLEN_W'(j) < pat_len && pat_buf[j] == CH_STAR) begin
        has_star = 1'b1;
        star_pos = PLEN_W'(j);
      end
    end
    has_caret = (pat_len != '0) && (pat_buf[0] == CH_CARET);
    pre_len   = has_star ? star_pos : pat_len;
    suf_off   = star_pos + PLEN_W'(1);
    suf_len   = has_star ? (pat_len - star_pos - PLEN_W'(1)) : '0;
  end

  // A leading '^' may sit on the virtual start, so scanning goes one lower
  assign pos_min = has_caret ? '1 : '0;
  assign suf_pos = pos + $signed(POS_W'(pre_len));

  sme_window_cmp u_pre (
    .str     (str_buf),
    .str_len (str_len),
    .pat     (pat_buf),
    .seg_off ('0),
    .seg_len (pre_len),
    .pos     (pos),
    .hit_c   (pre_hit)
  );

  sme_window_cmp u_suf (
    .str     (str_buf),
    .str_len (str_len),
    .pat     (pat_buf),
    .seg_off (POFF_W'(suf_off)),
    .seg_len (suf_len),
    .pos     (suf_pos),
    .hit_c   (suf_hit)
  );

  // Starts are scanned high to low so suf_seen accumulates "suffix fits at
  // some position >= pos + prefix_len"; the last hit seen is the leftmost.
  assign suf_ok      = suf_seen || suf_hit || (suf_len == '0);
  assign cand_hit    = pre_hit && suf_ok;
  assign search_done = (pos == pos_min);
  assign win_pos     = cand_hit ? pos : best_pos;
  assign idx_full    = win_pos + $signed(POS_W'(has_caret));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (isstring) state_next = LOAD_STR;
                else if (ispattern) state_next = LOAD_PAT;
      LOAD_STR: if (ispattern) state_next = LOAD_PAT;
      LOAD_PAT: if (!ispattern) state_next = SEARCH;
      SEARCH:   if (search_done) state_next = OUT;
      OUT:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Lengths, search registers and results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      str_len     <= '0;
      pat_len     <= '0;
      pos         <= '0;
      best_pos    <= '0;
      suf_seen    <= 1'b0;
      found       <= 1'b0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (isstring)       str_len <= SLEN_W'(1);
          else if (ispattern) pat_len <= PLEN_W'(1);
        end
        LOAD_STR: begin
          if (isstring) begin
            if (str_len < SLEN_W'(STR_MAX)) str_len <= str_len + SLEN_W'(1);
          end else if (ispattern) begin
            pat_len <= PLEN_W'(1);
          end
        end
        LOAD_PAT: begin
          if (ispattern) begin
            if (pat_len < PLEN_W'(PAT_MAX)) pat_len <= pat_len + PLEN_W'(1);
          end else begin
            pos      <= $signed(POS_W'(str_len));
            suf_seen <= 1'b0;
            found    <= 1'b0;
          end
        end
        SEARCH: begin
          suf_seen <= suf_ok;
          pos      <= pos - $signed(POS_W'(1));
          if (cand_hit) begin
            found    <= 1'b1;
            best_pos <= pos;
          end
          if (search_done) begin
            valid       <= 1'b1;
            match       <= found || cand_hit;
            match_index <= (found || cand_hit) ? IDX_W'(idx_full) : '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Character buffers; contents are qualified by the lengths
  always_ff @(posedge clk) begin
    if (isstring) begin
      if (state == IDLE)
        str_buf[0] <= chardata;
      else if (state == LOAD_STR && str_len < SLEN_W'(STR_MAX))
        str_buf[str_len[IDX_W-1:0]] <= chardata;
    end
    if (ispattern) begin
      if (state == IDLE || state == LOAD_STR)
        pat_buf[0] <= chardata;
      else if (state == LOAD_PAT && pat_len < PLEN_W'(PAT_MAX))
        pat_buf[pat_len[POFF_W-1:0]] <= chardata;
    end
  end

endmodule

// File: tb/tb_sme_string_match.sv
// Self-checking bench for sme_string_match: directed cases plus random
// strings/patterns compared against a behavioural matcher.
module tb_sme_string_match;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference copy of what the engine should hold
  byte m_str [32];
  int  m_slen = 0;
  byte m_pat [8];
  int  m_plen = 0;

  always #5 clk = ~clk;

  sme_string_match dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit chr_ok(byte pc, int i);
    bit  r = (i >= 0) && (i < m_slen);
    byte c = r ? m_str[i] : 8'sh00;
    if (pc == ".") return r;
    if (pc == "^") return (i == -1) || (r && c == " ");
    if (pc == "$") return (i == m_slen) || (r && c == " ");
    return r && (c == pc);
  endfunction

  function automatic bit seg_at(int off, int n, int p);
    for (int j = 0; j < n; j++)
      if (!chr_ok(m_pat[off + j], p + j)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void ref_result(output bit m, output int idx);
    int k = -1;
    int pre_n, suf_n, caret;
    bit ok;
    for (int j = m_plen - 1; j >= 0; j--) if (m_pat[j] == "*") k = j;
    pre_n = (k >= 0) ? k : m_plen;
    suf_n = (k >= 0) ? m_plen - k - 1 : 0;
    caret = (m_pat[0] == "^") ? 1 : 0;
    for (int s = -caret; s <= m_slen; s++) begin
      if (seg_at(0, pre_n, s)) begin
        ok = (suf_n == 0);
        for (int t = s + pre_n; t <= m_slen + 1; t++)
          if (seg_at(k + 1, suf_n, t)) ok = 1'b1;
        if (ok) begin
          m   = 1'b1;
          idx = (s + caret) & 31;
          return;
        end
      end
    end
    m   = 1'b0;
    idx = 0;
  endfunction

  // ---------------- drivers ----------------
  function automatic void to_q(input string s, output byte q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  task automatic send_bytes(input byte b[$], input bit is_pat);
    for (int i = 0; i < b.size(); i++) begin
      @(negedge clk);
      chardata  = b[i];
      isstring  = !is_pat;
      ispattern = is_pat;
      if (is_pat) begin
        if (i < 8) m_pat[i] = b[i];
      end else begin
        if (i < 32) m_str[i] = b[i];
      end
    end
    if (is_pat) m_plen = (b.size() > 8) ? 8 : b.size();
    else        m_slen = (b.size() > 32) ? 32 : b.size();
  endtask

  // Wait for the result pulse, check latency, values and pulse width
  task automatic wait_result(input string tag, input bit exp_m, input int exp_idx);
    int lat  = 0;
    bit seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (valid) seen = 1'b1;
      ispattern = 1'b0;
      isstring  = 1'b0;
    end
    if (!seen) begin
      check_eq({tag, " valid_seen"}, 0, 1);
      return;
    end
    check_eq({tag, " latency_ok"}, int'(lat <= 36), 1);
    check_eq({tag, " match"}, int'(match), int'(exp_m));
    check_eq({tag, " index"}, int'(match_index), exp_idx);
    @(negedge clk);
    check_eq({tag, " single_pulse"}, int'(valid), 0);
  endtask

  task automatic run_dir(input string s, input string p, input bit em, input int ei);
    byte q[$];
    if (s.len() > 0) begin
      to_q(s, q);
      send_bytes(q, 1'b0);
    end
    to_q(p, q);
    send_bytes(q, 1'b1);
    wait_result({"dir ", p}, em, ei);
  endtask

  task automatic run_rand(input int it, input bit new_str);
    string salph = "abc ";
    string palph = "abc. ";
    byte   q[$];
    int    n, lo, hi;
    bit    em;
    int    ei;
    if (new_str) begin
      n = $urandom_range(1, 34);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(salph[$urandom_range(0, 3)]);
      send_bytes(q, 1'b0);
    end
    n = $urandom_range(1, 8);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(palph[$urandom_range(0, 4)]);
    if ($urandom_range(0, 3) == 0) q[0] = "^";
    if (n > 1 && $urandom_range(0, 3) == 0) q[n-1] = "$";
    if ($urandom_range(0, 2) == 0) begin
      lo = (q[0] == "^") ? 1 : 0;
      hi = (n > 1 && q[n-1] == "$") ? n - 2 : n - 1;
      if (hi >= lo) q[$urandom_range(lo, hi)] = "*";
    end
    if (n == 8 && $urandom_range(0, 3) == 0) q.push_back("a");
    send_bytes(q, 1'b1);
    ref_result(em, ei);
    wait_result($sformatf("rand%0d", it), em, ei);
  endtask

  initial begin
    int pulses;
    byte q[$];
    reset     = 1'b0;
    chardata  = 8'h00;
    isstring  = 1'b0;
    ispattern = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset valid", int'(valid), 0);
    check_eq("reset match", int'(match), 0);
    check_eq("reset index", int'(match_index), 0);
    reset = 1'b1;
    @(negedge clk);

    run_dir("hello world", "wor", 1'b1, 6);
    run_dir("", "^wor", 1'b1, 6);
    run_dir("", "^orl", 1'b0, 0);
    run_dir("", "ld$", 1'b1, 9);
    run_dir("", "o$", 1'b1, 4);
    run_dir("", "o.w", 1'b1, 4);
    run_dir("", "xyz", 1'b0, 0);
    run_dir("", "he*ld", 1'b1, 0);
    run_dir("", "w*h", 1'b0, 0);
    run_dir("abcdefghijklmnopqrstuvwxyz012345", "^", 1'b1, 0);

    // Reset in the middle of a string load
    @(negedge clk);
    isstring = 1'b1; chardata = "q";
    @(negedge clk);
    chardata = "r";
    #2 reset = 1'b0;
    isstring = 1'b0;
    @(negedge clk);
    check_eq("midload_reset valid", int'(valid), 0);
    check_eq("midload_reset match", int'(match), 0);
    reset = 1'b1;
    m_slen = 0;
    run_dir("abc", "bc", 1'b1, 1);

    // Reset in the middle of a search: no result pulse may follow
    to_q("hello world", q);
    send_bytes(q, 1'b0);
    to_q("d", q);
    send_bytes(q, 1'b1);
    @(negedge clk);
    ispattern = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_slen = 0;
    pulses = 0;
    repeat (45) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check_eq("abort_no_valid", pulses, 0);

    for (int it = 0; it < 40; it++)
      run_rand(it, (it == 0) || ($urandom_range(0, 3) != 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
